barrel_shifter_pipe: RTL and testbench



---
 rtl/barrel_shifter_pipe.sv | 128 ++++++++++++
 tb/tb_barrel_shifter_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - pipelined LSR/LSL/ASR/ROR barrel shifter, one register stage per shift level
// Optional SHIFT_FLAGS_EN adds out_zero / out_lost aligned with out_data.
module barrel_shifter_pipe #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
`ifdef SHIFT_FLAGS_EN
    output logic                     out_zero,
    output logic                     out_lost,
`endif
    output logic [WIDTH-1:0]         out_data
);

    localparam int SHW      = $clog2(WIDTH);
    localparam int AMT_BITS = SHW * (SHW + 1) / 2;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_LSL = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    // Stage k holds the operand before level k; stage SHW is the output register.
    logic                    adv;
    logic [SHW:0]            valid_q, valid_d;
    logic [SHW:0][WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0][1:0]     mode_q, mode_d;
    logic [SHW-1:0]          sign_q, sign_d;
    // Amount bits packed triangularly: stage k keeps only its SHW-k unconsumed bits.
    logic [AMT_BITS-1:0]     amt_q, amt_d;
`ifdef SHIFT_FLAGS_EN
    logic [SHW:0]            lost_q, lost_d;
`endif

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] mode,
                                                  input logic sign, input int sh);
        logic [WIDTH-1:0] ones;
        ones = '1;
        case (mode)
            MODE_LSR: shift_by = d >> sh;
            MODE_LSL: shift_by = d << sh;
            MODE_ASR: shift_by = (d >> sh) | (sign ? ~(ones >> sh) : '0);
            default:  shift_by = (d >> sh) | (d << (WIDTH - sh));
        endcase
    endfunction

`ifdef SHIFT_FLAGS_EN
    function automatic logic bits_lost(input logic [WIDTH-1:0] d, input logic [1:0] mode,
                                       input int sh);
        logic [WIDTH-1:0] ones;
        ones = '1;
        case (mode)
            MODE_LSR, MODE_ASR: bits_lost = |(d & ~(ones << sh));
            MODE_LSL:           bits_lost = |(d & ~(ones >> sh));
            default:            bits_lost = 1'b0;
        endcase
    endfunction
`endif

    assign adv      = ~valid_q[SHW] | out_ready;
    assign in_ready = adv;

    assign valid_d           = {valid_q[SHW-1:0], in_valid};
    assign data_d[0]         = in_data;
    assign amt_d[SHW-1:0]    = in_amt;
    assign mode_d            = {mode_q[SHW-2:0], in_mode};
    assign sign_d            = {sign_q[SHW-2:0], in_data[WIDTH-1]};

    for (genvar k = 0; k < SHW; k++) begin : g_lvl
        localparam int SH  = 1 << (SHW - 1 - k);
        localparam int NB  = SHW - k;
        localparam int OFF = k * SHW - (k * (k - 1)) / 2;
        logic take;

        assign take          = amt_q[OFF + NB - 1];
        assign data_d[k + 1] = take ? shift_by(data_q[k], mode_q[k], sign_q[k], SH) : data_q[k];
        if (k < SHW - 1) begin : g_amt
            assign amt_d[OFF + NB +: NB - 1] = amt_q[OFF +: NB - 1];
        end
`ifdef SHIFT_FLAGS_EN
        assign lost_d[k + 1] = lost_q[k] | (take & bits_lost(data_q[k], mode_q[k], SH));
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
            sign_q  <= '0;
        end else if (adv) begin
            valid_q <= valid_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
            sign_q  <= sign_d;
        end
    end

    assign out_valid = valid_q[SHW];
    assign out_data  = data_q[SHW];

`ifdef SHIFT_FLAGS_EN
    assign lost_d[0] = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            lost_q <= '0;
        end else if (adv) begin
            lost_q <= lost_d;
        end
    end

    assign out_zero = (data_q[SHW] == '0);
    assign out_lost = lost_q[SHW];
`else
    // Without flags the output stage carries only valid and data.
`endif

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - table-driven and sequence checks for barrel_shifter_pipe
module tb_barrel_shifter_pipe;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;
    localparam int NVEC  = 15;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef SHIFT_FLAGS_EN
    logic             out_zero;
    logic             out_lost;
`endif

    barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef SHIFT_FLAGS_EN
        .out_zero  (out_zero),
        .out_lost  (out_lost),
`endif
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] din;
        logic [3:0]  amt;
        logic [1:0]  mode;
        logic [15:0] exp;
        logic        zero;
        logic        lost;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_cmp;
    int   n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int lat;
        logic got;
        int cnt;

        n_cmp = 0;
        n_bad = 0;
        // din, amt, mode, expected data, zero, lost
        vecs[0]  = '{16'hB6F1, 4'd4,  2'b00, 16'h0B6F, 1'b0, 1'b1};
        vecs[1]  = '{16'hB6F1, 4'd0,  2'b00, 16'hB6F1, 1'b0, 1'b0};
        vecs[2]  = '{16'h00FF, 4'd9,  2'b01, 16'hFE00, 1'b0, 1'b1};
        vecs[3]  = '{16'h0001, 4'd15, 2'b01, 16'h8000, 1'b0, 1'b0};
        vecs[4]  = '{16'h8F00, 4'd8,  2'b10, 16'hFF8F, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, 1'b0};
        vecs[6]  = '{16'h7FFF, 4'd15, 2'b10, 16'h0000, 1'b1, 1'b1};
        vecs[7]  = '{16'h1234, 4'd4,  2'b11, 16'h4123, 1'b0, 1'b0};
        vecs[8]  = '{16'h8001, 4'd1,  2'b11, 16'hC000, 1'b0, 1'b0};
        vecs[9]  = '{16'hB6F1, 4'd0,  2'b01, 16'hB6F1, 1'b0, 1'b0};
        vecs[10] = '{16'hB6F1, 4'd0,  2'b11, 16'hB6F1, 1'b0, 1'b0};
        vecs[11] = '{16'h4000, 4'd1,  2'b10, 16'h2000, 1'b0, 1'b0};
        vecs[12] = '{16'hFFFF, 4'd15, 2'b00, 16'h0001, 1'b0, 1'b1};
        vecs[13] = '{16'h0001, 4'd15, 2'b11, 16'h0002, 1'b0, 1'b0};
        vecs[14] = '{16'h8000, 4'd1,  2'b01, 16'h0000, 1'b1, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            in_amt   = vecs[i].amt;
            in_mode  = vecs[i].mode;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 0;
            got = 1'b0;
            while (!got && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
                got = out_valid;
            end
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(SHW));
            check($sformatf("vec%0d data", i), 32'(out_data), 32'(vecs[i].exp));
`ifdef SHIFT_FLAGS_EN
            check($sformatf("vec%0d zero", i), 32'(out_zero), 32'(vecs[i].zero));
            check($sformatf("vec%0d lost", i), 32'(out_lost), 32'(vecs[i].lost));
`endif
        end
        repeat (3) @(posedge clk);
        #1;

        fork
            begin : drv
                logic acc;
                for (int i = 0; i < 8; i++) begin
                    in_valid = 1'b1;
                    in_data  = vecs[i].din;
                    in_amt   = vecs[i].amt;
                    in_mode  = vecs[i].mode;
                    acc = 1'b0;
                    for (int t = 0; t < 50 && !acc; t++) begin
                        @(negedge clk);
                        #2;
                        acc = in_ready;
                        @(posedge clk);
                        #1;
                    end
                    check($sformatf("stream accept %0d", i), 32'(acc), 32'd1);
                end
                in_valid = 1'b0;
            end
            begin : mon
                logic        seen;
                logic [15:0] held;
                int          idx;
                int          extra;
                seen = 1'b0;
                for (int t = 0; t < 50 && !seen; t++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                check("stream first valid", 32'(seen), 32'd1);
                out_ready = 1'b0;
                #1;
                held = out_data;
                check("stall in_ready c0", 32'(in_ready), 32'd0);
                for (int s = 1; s < 3; s++) begin
                    @(negedge clk);
                    check($sformatf("stall in_ready c%0d", s), 32'(in_ready), 32'd0);
                    check($sformatf("stall out_valid c%0d", s), 32'(out_valid), 32'd1);
                    check($sformatf("stall out_data c%0d", s), 32'(out_data), 32'(held));
                end
                out_ready = 1'b1;
                idx = 0;
                for (int t = 0; t < 100 && idx < 8; t++) begin
                    if (out_valid) begin
                        check($sformatf("stream data %0d", idx), 32'(out_data), 32'(vecs[idx].exp));
                        idx++;
                    end
                    @(negedge clk);
                end
                check("stream count", 32'(idx), 32'd8);
                extra = 0;
                for (int t = 0; t < 10; t++) begin
                    if (out_valid) extra++;
                    @(negedge clk);
                end
                check("stream no duplicates", 32'(extra), 32'd0);
            end
        join

        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            in_amt   = vecs[i].amt;
            in_mode  = vecs[i].mode;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("post-reset in_ready", 32'(in_ready), 32'd1);
        check("post-reset out_valid", 32'(out_valid), 32'd0);
        check("post-reset out_data", 32'(out_data), 32'd0);
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("reset flush", 32'(cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
